cpu_ctrl: RTL and testbench

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/cpu_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cpu_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg -- shared definitions for the 8-bit accumulator CPU controller.
//
// Holds the data width, the instruction opcodes, the ALU operation codes
// (shared with the ALU sitting beside cpu_ctrl) and the controller state
// encoding. Also provides small opcode-classification helpers.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 8;

    // Instruction opcodes (upper nibble of the instruction byte)
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDB = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_LDA = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_OUT = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ALU operation codes; for opcodes 2..7 the ALU code equals the opcode
    localparam logic [3:0] ALU_ZERO  = 4'h0;
    localparam logic [3:0] ALU_PASSB = 4'h1;
    localparam logic [3:0] ALU_ADD   = 4'h2;
    localparam logic [3:0] ALU_SUB   = 4'h3;
    localparam logic [3:0] ALU_AND   = 4'h4;
    localparam logic [3:0] ALU_OR    = 4'h5;
    localparam logic [3:0] ALU_XOR   = 4'h6;
    localparam logic [3:0] ALU_NOT   = 4'h7;

    // Controller states
    localparam logic [2:0] ST_FETCH     = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_IMM_FETCH = 3'd2;
    localparam logic [2:0] ST_IMM_LATCH = 3'd3;
    localparam logic [2:0] ST_EXEC      = 3'd4;
    localparam logic [2:0] ST_OUT_WAIT  = 3'd5;
    localparam logic [2:0] ST_HALT      = 3'd6;

    // Opcodes followed by one immediate byte
    function automatic logic needs_imm(input logic [3:0] op);
        return (op == OP_LDB) || (op == OP_LDA) || (op == OP_JMP) ||
               (op == OP_JC)  || (op == OP_JZ);
    endfunction

    // Opcodes whose ALU result is written to ACC/C/Z
    function automatic logic writes_acc(input logic [3:0] op);
        return ((op >= OP_ADD) && (op <= OP_NOT)) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_ctrl -- multi-cycle control unit of an 8-bit accumulator CPU.
//
// Fetches instructions from a synchronous-read instruction memory, drives an
// external combinational ALU, owns PC/ACC/B/IR/IMM and the C/Z flags, and
// presents a valid/ready output port. The ALU lives beside this block.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   step              (only with CPU_CTRL_STEP_EN) FETCH advances when high
//   imem_addr/_data   instruction memory address / read data (1-cycle latency)
//   alu_op/a/b        ALU operation and operands (a = ACC, b = B or IMM)
//   alu_o/c/z         ALU result, carry/borrow and zero flag
//   out_data/valid    output port value and valid; out_ready handshake input
//   halted            high while in HALT
//
// Configuration macro: CPU_CTRL_STEP_EN adds the step input for single-step
// execution (one instruction per step pulse).
// ---------------------------------------------------------------------------
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CPU_CTRL_STEP_EN
    input  logic              step,
`endif
    output logic [DATA_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_o,
    input  logic              alu_c,
    input  logic              alu_z,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted
);

    logic [2:0]        state_reg;
    logic [DATA_W-1:0] pc_reg;
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] b_reg;
    logic [3:0]        ir_reg;      // only the opcode nibble carries meaning
    logic [DATA_W-1:0] imm_reg;
    logic              c_reg;
    logic              z_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_valid_reg;
    logic              fetch_go;
    logic [3:0]        dec_op;
    logic              operand_nibble_unused;

    assign dec_op = imem_data[7:4];
    // The low nibble of an instruction byte has no function in this ISA.
    assign operand_nibble_unused = ^imem_data[3:0];

`ifdef CPU_CTRL_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_FETCH;
            pc_reg        <= RESET_PC;
            acc_reg       <= '0;
            b_reg         <= '0;
            ir_reg        <= '0;
            imm_reg       <= '0;
            c_reg         <= 1'b0;
            z_reg         <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (fetch_go) begin
                        state_reg <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    ir_reg <= dec_op;
                    pc_reg <= pc_reg + 8'd1;
                    if (needs_imm(dec_op)) begin
                        state_reg <= ST_IMM_FETCH;
                    end else if (dec_op == OP_OUT) begin
                        // Output is captured on entry and held for the handshake
                        out_data_reg  <= acc_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_OUT_WAIT;
                    end else if (dec_op == OP_HLT) begin
                        state_reg <= ST_HALT;
                    end else if ((dec_op == OP_NOP) || (dec_op == 4'hD) || (dec_op == 4'hE)) begin
                        state_reg <= ST_FETCH;
                    end else begin
                        state_reg <= ST_EXEC;
                    end
                end
                ST_IMM_FETCH: begin
                    state_reg <= ST_IMM_LATCH;
                end
                ST_IMM_LATCH: begin
                    imm_reg   <= imem_data;
                    pc_reg    <= pc_reg + 8'd1;
                    state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (writes_acc(ir_reg)) begin
                        acc_reg <= alu_o;
                        c_reg   <= alu_c;
                        z_reg   <= alu_z;
                    end
                    if (ir_reg == OP_LDB) begin
                        b_reg <= imm_reg;
                    end
                    if ((ir_reg == OP_JMP) ||
                        ((ir_reg == OP_JC) && c_reg) ||
                        ((ir_reg == OP_JZ) && z_reg)) begin
                        pc_reg <= imm_reg;
                    end
                    state_reg <= ST_FETCH;
                end
                ST_OUT_WAIT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state_reg <= ST_HALT;
                end
                default: begin
                    state_reg <= ST_FETCH;
                end
            endcase
        end
    end

    // ALU drive: only EXEC issues a real operation; LDA routes IMM through
    // the pass-B path so ACC and flags are loaded by the ALU.
    always_comb begin
        alu_op = ALU_ZERO;
        alu_b  = b_reg;
        if (state_reg == ST_EXEC) begin
            if (ir_reg == OP_LDA) begin
                alu_op = ALU_PASSB;
                alu_b  = imm_reg;
            end else if ((ir_reg >= OP_ADD) && (ir_reg <= OP_NOT)) begin
                alu_op = ir_reg;
            end
        end
    end

    assign alu_a     = acc_reg;
    assign imem_addr = pc_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign halted    = (state_reg == ST_HALT);

endmodule

// File: tb/tb_cpu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl -- self-checking bench for cpu_ctrl.
// An instruction-level model expands each instruction into its expected
// per-cycle outputs (queue of records); every cycle is compared. Directed
// programs pin final results with literal values; random programs follow.
// Build with CPU_CTRL_STEP_EN defined to exercise the step input.
// ---------------------------------------------------------------------------
module tb_cpu_ctrl;

    localparam int T_F = 1, T_D = 2, T_I = 3, T_L = 4, T_E = 5, T_W = 6, T_H = 7, T_S = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] imem_addr, imem_data, alu_a, alu_b, alu_o, out_data;
    logic [3:0] alu_op;
    logic       alu_c, alu_z, out_valid, out_ready, halted;
`ifdef CPU_CTRL_STEP_EN
    logic       step = 1'b0;
`endif

    always #5 clk = ~clk;

    cpu_ctrl #(.RESET_PC(8'h00)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef CPU_CTRL_STEP_EN
        .step     (step),
`endif
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .alu_op   (alu_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_o    (alu_o),
        .alu_c    (alu_c),
        .alu_z    (alu_z),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .halted   (halted)
    );

    // Environment: synchronous-read instruction memory and combinational ALU
    logic [7:0] mem [256];
    always @(posedge clk) imem_data <= mem[imem_addr];

    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h1:    return {1'b0, b};
            4'h2:    return {1'b0, a} + {1'b0, b};
            4'h3:    return {1'b0, a} - {1'b0, b};
            4'h4:    return {1'b0, a & b};
            4'h5:    return {1'b0, a | b};
            4'h6:    return {1'b0, a ^ b};
            4'h7:    return {1'b0, ~a};
            default: return 9'h000;
        endcase
    endfunction

    always_comb begin
        {alu_c, alu_o} = alu_f(alu_op, alu_a, alu_b);
        alu_z = (alu_o == 8'h00);
    end

    // Expected outputs for one cycle plus the inputs to drive in that cycle
    typedef struct {
        int         tag;
        logic       ca;
        logic [7:0] addr;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       ov;
        logic [7:0] od;
        logic       hl;
        logic       rdy;
        logic       stp;
    } rec_t;

    rec_t q[$];
    logic [7:0] m_pc, m_acc, m_b;
    logic       m_c, m_z, m_halt;
    int force_wait = -1;
    int compared = 0, mismatched = 0;
    int cyc = 0, add_cyc = 0, vcnt = 0;
    int rst_tag = 0;
    logic rst_done = 1'b0, halt_seen = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic rec_t mk(input int tag, input logic ca, input logic [3:0] op,
                                input logic [7:0] bv, input logic ov, input logic [7:0] od,
                                input logic rdy, input logic stp);
        rec_t r;
        r.tag = tag; r.ca = ca; r.addr = m_pc; r.op = op; r.a = m_acc; r.b = bv;
        r.ov = ov; r.od = od; r.hl = m_halt; r.rdy = rdy; r.stp = stp;
        return r;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic model_reset();
        m_pc = 8'h00; m_acc = 8'h00; m_b = 8'h00;
        m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0;
        q.delete();
    endtask

    // Expand the instruction at m_pc into cycle records and apply its effect
    task automatic gen_instr();
        logic [3:0] op;
        logic [7:0] imm;
        logic [8:0] res;
        int n;
        if (m_halt) begin
            q.push_back(mk(T_H, 1'b0, 4'h0, m_b, 1'b0, 8'h00, rbit(), 1'b1));
            return;
        end
`ifdef CPU_CTRL_STEP_EN
        n = $urandom_range(0, 2);
        repeat (n) q.push_back(mk(T_S, 1'b1, 4'h0, m_b, 1'b0, 8'h00, rbit(), 1'b0));
`endif
        op = mem[m_pc][7:4];
        q.push_back(mk(T_F, 1'b1, 4'h0, m_b, 1'b0, 8'h00, rbit(), 1'b1));
        q.push_back(mk(T_D, 1'b0, 4'h0, m_b, 1'b0, 8'h00, rbit(), 1'b0));
        m_pc = m_pc + 8'd1;
        if (op == 4'h1 || op == 4'h8 || op == 4'h9 || op == 4'hA || op == 4'hB) begin
            q.push_back(mk(T_I, 1'b1, 4'h0, m_b, 1'b0, 8'h00, rbit(), 1'b0));
            q.push_back(mk(T_L, 1'b0, 4'h0, m_b, 1'b0, 8'h00, rbit(), 1'b0));
            imm = mem[m_pc];
            m_pc = m_pc + 8'd1;
            if (op == 4'h8) q.push_back(mk(T_E, 1'b0, 4'h1, imm, 1'b0, 8'h00, rbit(), 1'b0));
            else            q.push_back(mk(T_E, 1'b0, 4'h0, m_b, 1'b0, 8'h00, rbit(), 1'b0));
            case (op)
                4'h1: m_b = imm;
                4'h8: begin
                    res = alu_f(4'h1, m_acc, imm);
                    m_acc = res[7:0]; m_c = res[8]; m_z = (res[7:0] == 8'h00);
                end
                4'h9: m_pc = imm;
                4'hA: if (m_c) m_pc = imm;
                default: if (m_z) m_pc = imm;
            endcase
        end else if (op >= 4'h2 && op <= 4'h7) begin
            q.push_back(mk(T_E, 1'b0, op, m_b, 1'b0, 8'h00, rbit(), 1'b0));
            res = alu_f(op, m_acc, m_b);
            m_acc = res[7:0]; m_c = res[8]; m_z = (res[7:0] == 8'h00);
        end else if (op == 4'hC) begin
            n = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
            force_wait = -1;
            repeat (n) q.push_back(mk(T_W, 1'b0, 4'h0, m_b, 1'b1, m_acc, 1'b0, 1'b0));
            q.push_back(mk(T_W, 1'b0, 4'h0, m_b, 1'b1, m_acc, 1'b1, 1'b0));
        end else if (op == 4'hF) begin
            m_halt = 1'b1;
        end
    endtask

    // One clock cycle: compare at the negedge, then drive the next inputs
    task automatic tick();
        rec_t r;
        if (q.size() == 0) gen_instr();
        r = q.pop_front();
        cyc++;
        if (r.ca) cmp("imem_addr", {24'h0, imem_addr}, {24'h0, r.addr});
        cmp("alu_op", {28'h0, alu_op}, {28'h0, r.op});
        cmp("alu_a", {24'h0, alu_a}, {24'h0, r.a});
        cmp("alu_b", {24'h0, alu_b}, {24'h0, r.b});
        cmp("out_valid", {31'h0, out_valid}, {31'h0, r.ov});
        cmp("halted", {31'h0, halted}, {31'h0, r.hl});
        if (r.ov) cmp("out_data", {24'h0, out_data}, {24'h0, r.od});
        if (out_valid === 1'b1) vcnt++;
        if (out_valid === 1'b1 && r.rdy) $display("out transfer data=%h at cyc %0d", out_data, cyc);
        if (add_cyc == 0 && alu_op == 4'h2) add_cyc = cyc;
        if (halted === 1'b1) halt_seen = 1'b1;
        out_ready = r.rdy;
`ifdef CPU_CTRL_STEP_EN
        step = r.stp;
`endif
        if (rst_tag != 0 && r.tag == rst_tag) begin
            rst = 1'b1; rst_tag = 0; rst_done = 1'b1;
            model_reset();
        end else begin
            rst = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; out_ready = 1'b0;
`ifdef CPU_CTRL_STEP_EN
        step = 1'b0;
`endif
        model_reset();
        cyc = 0; add_cyc = 0; vcnt = 0; rst_done = 1'b0; halt_seen = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_state();
        cmp("rst_addr", {24'h0, imem_addr}, 32'h00);
        cmp("rst_valid", {31'h0, out_valid}, 32'h0);
        cmp("rst_halted", {31'h0, halted}, 32'h0);
        cmp("rst_alu_op", {28'h0, alu_op}, 32'h0);
        cmp("rst_acc", {24'h0, alu_a}, 32'h00);
        cmp("rst_b", {24'h0, alu_b}, 32'h00);
    endtask

    task automatic run_to_halt(input int budget);
        halt_seen = 1'b0;
        for (int i = 0; i < budget && !halt_seen; i++) tick();
        cmp("halt_reached", {31'h0, halt_seen}, 32'h1);
    endtask

    task automatic wait_rst(input int budget);
        for (int i = 0; i < budget && !rst_done; i++) tick();
        cmp("mid_reset_hit", {31'h0, rst_done}, 32'h1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic load(input logic [7:0] base, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                        input logic [7:0] b5, input logic [7:0] b6);
        mem[base] = b0; mem[base+8'd1] = b1; mem[base+8'd2] = b2; mem[base+8'd3] = b3;
        mem[base+8'd4] = b4; mem[base+8'd5] = b5; mem[base+8'd6] = b6;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        out_ready = 1'b0;

        // LDA 05, LDB 03, ADD, HLT
        clear_mem();
        load(8'h00, 8'h81, 8'h05, 8'h11, 8'h03, 8'h20, 8'hF0, 8'h00);
        do_reset();
        check_reset_state();
        run_to_halt(200);
        cmp("p1_acc", {24'h0, alu_a}, 32'h08);
        cmp("p1_pc", {24'h0, imem_addr}, 32'h06);
        cmp("p1_halted", {31'h0, halted}, 32'h1);
`ifndef CPU_CTRL_STEP_EN
        cmp("p1_add_exec_cycle", add_cyc, 13);
`endif

        // LDA FF, LDB 01, ADD (C=1,Z=1), JC 10, JZ 20, HLT
        clear_mem();
        load(8'h00, 8'h80, 8'hFF, 8'h10, 8'h01, 8'h20, 8'hA0, 8'h10);
        mem[8'h10] = 8'hB0; mem[8'h11] = 8'h20; mem[8'h20] = 8'hF0;
        do_reset();
        run_to_halt(200);
        cmp("p2_acc", {24'h0, alu_a}, 32'h00);
        cmp("p2_pc", {24'h0, imem_addr}, 32'h21);

        // LDA 05, LDB 05, SUB, JZ 40; LDA 03, SUB -> FE C=1 Z=0; JZ 50 not taken; JC 60
        clear_mem();
        load(8'h00, 8'h80, 8'h05, 8'h10, 8'h05, 8'h30, 8'hB0, 8'h40);
        load(8'h40, 8'h80, 8'h03, 8'h30, 8'hB0, 8'h50, 8'hA0, 8'h60);
        mem[8'h50] = 8'hF0; mem[8'h60] = 8'hF0;
        do_reset();
        run_to_halt(200);
        cmp("p3_acc", {24'h0, alu_a}, 32'hFE);
        cmp("p3_pc", {24'h0, imem_addr}, 32'h61);

        // OUT held off by out_ready=0 for 4 cycles
        clear_mem();
        load(8'h00, 8'h80, 8'h5A, 8'hC0, 8'hF0, 8'h00, 8'h00, 8'h00);
        force_wait = 4;
        do_reset();
        run_to_halt(200);
        cmp("p4_valid_cycles", vcnt, 5);
        cmp("p4_acc", {24'h0, alu_a}, 32'h5A);

        // Reset during IMM_LATCH, then full restart
        clear_mem();
        load(8'h00, 8'h80, 8'h5A, 8'h10, 8'h33, 8'hF0, 8'h00, 8'h00);
        do_reset();
        rst_tag = T_L;
        wait_rst(50);
        check_reset_state();
        run_to_halt(200);
        cmp("p5_acc", {24'h0, alu_a}, 32'h5A);
        cmp("p5_b", {24'h0, alu_b}, 32'h33);

        // Reset during OUT_WAIT drops the pending output
        clear_mem();
        load(8'h00, 8'h80, 8'h5A, 8'hC0, 8'hF0, 8'h00, 8'h00, 8'h00);
        force_wait = 3;
        do_reset();
        rst_tag = T_W;
        wait_rst(50);
        check_reset_state();
        run_to_halt(200);
        cmp("p6_acc", {24'h0, alu_a}, 32'h5A);

        // Wrap: JMP FF; LDA at FF takes its immediate from 00; HLT at 01
        clear_mem();
        mem[8'h00] = 8'h90; mem[8'h01] = 8'hFF; mem[8'hFF] = 8'h80;
        do_reset();
        run_to_halt(200);
        cmp("p7_acc", {24'h0, alu_a}, 32'h90);
        cmp("p7_pc", {24'h0, imem_addr}, 32'h02);

        // Random programs (HLT made rare so execution runs longer)
        for (int p = 0; p < 25; p++) begin
            for (int i = 0; i < 256; i++) begin
                v = 8'($urandom);
                if (v[7:4] == 4'hF && $urandom_range(0, 7) != 0) v[7:4] = 4'h2;
                mem[i] = v;
            end
            do_reset();
            check_reset_state();
            repeat (150) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
